mem_port_arbiter: RTL and testbench

- Arbitrates one shared single-port memory bus between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline.
- Generates the per-stage memory stalls consumed by the pipeline stall logic.
- Sequences each transfer through a request/ack bus handshake, with data-priority arbitration and an anti-starvation limit for fetch.

---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_arb_priority.sv | 36 +++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM states, grant owner
// and the data-streak counter helper.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUS_I,
      BUS_D,
      RESP
   } arb_state_t;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } grant_owner_t;

   localparam int unsigned STREAK_W = 4;

   function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s,
                                                      input logic [STREAK_W-1:0] lim);
      return (s >= lim) ? lim : s + 1'b1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_priority.sv
// Combinational grant decision: data wins over fetch unless the data streak has
// reached its limit while a fetch is waiting.
module arb_priority
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned D_STREAK_MAX = 4
) (
   input  logic                if_req,
   input  logic                if_kill,
   input  logic                d_req,
   input  logic [STREAK_W-1:0] streak,
   output logic                grant,
   output grant_owner_t        owner,
   output logic [STREAK_W-1:0] streak_next
);

   localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(D_STREAK_MAX);

   logic fetch_pend;

   assign fetch_pend = if_req & ~if_kill;

   always_comb begin
      grant       = fetch_pend | d_req;
      owner       = GRANT_D;
      streak_next = streak;
      if (fetch_pend && (!d_req || streak == LIMIT)) begin
         owner       = GRANT_I;
         streak_next = '0;
      end else if (d_req) begin
         // the streak only grows while a fetch is actually being held off
         streak_next = fetch_pend ? streak_inc(streak, LIMIT) : '0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between fetch and data stages.
// Optional bus watchdog enabled by defining BUS_TIMEOUT_EN.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned D_STREAK_MAX   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_kill,
   output logic                if_done,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic                d_done,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                stall_if,
   output logic                stall_mem,
   output logic                bus_req,
   output logic                bus_we,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_be,
   input  logic                bus_ack,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic                bus_err
);

   arb_state_t          state;
   logic [STREAK_W-1:0] streak;
   logic [STREAK_W-1:0] streak_next;
   logic                grant;
   grant_owner_t        grant_owner;
   logic                if_done_r;
   logic                killed;
   logic                tmo_hit;
   logic                complete;
   logic [DATA_W-1:0]   cpl_data;

   arb_priority #(
      .D_STREAK_MAX(D_STREAK_MAX)
   ) u_prio (
      .if_req     (if_req),
      .if_kill    (if_kill),
      .d_req      (d_req),
      .streak     (streak),
      .grant      (grant),
      .owner      (grant_owner),
      .streak_next(streak_next)
   );

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 256) ? 8 : 16;

   logic [TMO_W-1:0] tmo_cnt;
   logic             err_r;

   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
   assign bus_err = err_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt <= '0;
         err_r   <= 1'b0;
      end else if (state == BUS_I || state == BUS_D) begin
         if (tmo_hit && !bus_ack) err_r <= 1'b1;
         tmo_cnt <= complete ? '0 : tmo_cnt + 1'b1;
      end else begin
         tmo_cnt <= '0;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign bus_err = 1'b0;
`endif

   // a watchdog expiry completes the transfer with zero data
   assign complete = bus_ack | tmo_hit;
   assign cpl_data = bus_ack ? bus_rdata : '0;

   // a flush arriving during the response cycle still cancels the pulse
   assign if_done   = if_done_r & ~if_kill;
   assign stall_if  = if_req & ~if_done & ~if_kill;
   assign stall_mem = d_req & ~d_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         streak    <= '0;
         killed    <= 1'b0;
         if_done_r <= 1'b0;
         d_done    <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= '0;
      end else begin
         if_done_r <= 1'b0;
         d_done    <= 1'b0;
         case (state)
            IDLE: begin
               if (grant) begin
                  streak  <= streak_next;
                  killed  <= 1'b0;
                  bus_req <= 1'b1;
                  if (grant_owner == GRANT_I) begin
                     state     <= BUS_I;
                     bus_we    <= 1'b0;
                     bus_addr  <= if_addr;
                     bus_wdata <= '0;
                     bus_be    <= '1;
                  end else begin
                     state     <= BUS_D;
                     bus_we    <= d_we;
                     bus_addr  <= d_addr;
                     bus_wdata <= d_wdata;
                     bus_be    <= d_be;
                  end
               end
            end
            BUS_I, BUS_D: begin
               if (state == BUS_I && if_kill) killed <= 1'b1;
               if (complete) begin
                  bus_req <= 1'b0;
                  state   <= RESP;
                  if (state == BUS_I) begin
                     if_rdata  <= cpl_data;
                     if_done_r <= ~(killed | if_kill);
                  end else begin
                     if (!bus_we) d_rdata <= cpl_data;
                     d_done <= 1'b1;
                  end
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of grants, bus timing and done pulses.
module tb_mem_port_arbiter;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int          SMAX = 4;
   localparam int          TMO  = 255;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, if_kill, if_done;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          d_req, d_we, d_done;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic [3:0]    d_be;
   logic          stall_if, stall_mem;
   logic          bus_req, bus_we, bus_ack, bus_err;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata, bus_rdata;
   logic [3:0]    bus_be;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .D_STREAK_MAX(SMAX), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_done(if_done), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_done(d_done), .d_rdata(d_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int k = 0;

   // transaction-level reference state
   bit          act, own_d, killed, e_err;
   int          gcyc, acyc, free_at, streak, waitc, ack_delay;
   logic [31:0] eb_addr, eb_wdata, e_if_rdata, e_d_rdata;
   logic        eb_we;
   logic [3:0]  eb_be;

   // stimulus controls and observations
   bit          rand_delay, spurious, rd_force_en, force_ack, prev_req;
   int          next_delay;
   logic [31:0] rd_force;
   int          if_done_cnt, d_done_cnt, last_if_done_k;
   logic [31:0] rise_log[$];
   int          rise_k[$];
   logic        obs_we;
   logic [3:0]  obs_be;
   logic [31:0] obs_wdata;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: got %h expected %h", tag, k, obs, exp);
      end
   endtask

   task automatic model_clear();
      act = 0; own_d = 0; killed = 0; e_err = 0;
      gcyc = 0; acyc = -1; free_at = 0; streak = 0; waitc = 0; ack_delay = 0;
      eb_addr = '0; eb_wdata = '0; eb_we = 1'b0; eb_be = '0;
      e_if_rdata = '0; e_d_rdata = '0;
      prev_req = 0;
   endtask

   task automatic capture(input logic [31:0] data);
      acyc    = k;
      free_at = k + 2;
      if (!own_d) e_if_rdata = data;
      else if (!eb_we) e_d_rdata = data;
   endtask

   // One clock: entered just after a rising edge with requester inputs set.
   task automatic cycle();
      bit e_req, resp, e_ifd, e_dd, fp, dp, gi;
      e_req = act && acyc < 0 && k > gcyc;
      bus_ack = 1'b0;
      if (force_ack) begin
         bus_ack = 1'b1;
         force_ack = 0;
      end else if (e_req) bus_ack = (waitc >= ack_delay);
      else if (spurious) bus_ack = ($urandom_range(0, 3) == 0);
      bus_rdata = rd_force_en ? rd_force : $urandom;
      #1;
      resp  = act && acyc >= 0 && k == acyc + 1;
      e_ifd = resp && !own_d && !killed && !if_kill;
      e_dd  = resp && own_d;
      chk("bus_req", bus_req, e_req);
      chk("bus_addr", bus_addr, eb_addr);
      chk("bus_we", bus_we, eb_we);
      chk("bus_wdata", bus_wdata, eb_wdata);
      chk("bus_be", bus_be, eb_be);
      chk("if_done", if_done, e_ifd);
      chk("d_done", d_done, e_dd);
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
      chk("stall_if", stall_if, if_req & ~e_ifd & ~if_kill);
      chk("stall_mem", stall_mem, d_req & ~e_dd);
      chk("bus_err", bus_err, e_err);
      if (if_done) begin
         if_done_cnt++;
         last_if_done_k = k;
      end
      if (d_done) d_done_cnt++;
      if (bus_req && !prev_req) begin
         rise_log.push_back(bus_addr);
         rise_k.push_back(k);
         obs_we = bus_we; obs_be = bus_be; obs_wdata = bus_wdata;
      end
      prev_req = bus_req;
      @(posedge clk);
      #1;
      if (act && !own_d && k > gcyc && if_kill) killed = 1;
      if (e_req) begin
         if (bus_ack) capture(bus_rdata);
         else begin
            waitc++;
`ifdef BUS_TIMEOUT_EN
            if (k - gcyc == TMO) begin
               capture('0);
               e_err = 1;
            end
`endif
         end
      end
      if (resp) act = 0;
      if (!act && k >= free_at) begin
         fp = if_req && !if_kill;
         dp = d_req;
         if (fp || dp) begin
            gi = fp && (!dp || streak == SMAX);
            if (gi) streak = 0;
            else streak = fp ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
            act = 1; own_d = !gi; gcyc = k; acyc = -1; killed = 0; waitc = 0;
            ack_delay = rand_delay ? $urandom_range(0, 3) : next_delay;
            if (gi) begin
               eb_addr = if_addr; eb_we = 1'b0; eb_wdata = '0; eb_be = 4'hF;
            end else begin
               eb_addr = d_addr; eb_we = d_we; eb_wdata = d_wdata; eb_be = d_be;
            end
         end
      end
      if (e_ifd) if_req = 1'b0;
      if (e_dd) d_req = 1'b0;
      if (if_kill) begin
         if_kill = 1'b0;
         if_req  = 1'b0;
      end
      k++;
   endtask

   task automatic do_reset(input bit late_ack);
      rst = 1'b1; if_req = 1'b0; if_kill = 1'b0; d_req = 1'b0; d_we = 1'b0;
      bus_ack = late_ack;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus_ack = 1'b0;
      model_clear();
      k++;
   endtask

   task automatic drain(input int maxc);
      for (int i = 0; i < maxc && (act || if_req || d_req); i++) cycle();
      chk("drain_reqs", {30'd0, if_req, d_req}, 32'd0);
      chk("drain_bus_req", bus_req, 1'b0);
   endtask

   initial begin
      int          t0, base, dn;
      logic [31:0] saved;
      logic [31:0] exp_order[6];
      rst = 1'b1; if_req = 0; if_addr = '0; if_kill = 0; d_req = 0; d_we = 0;
      d_addr = '0; d_wdata = '0; d_be = '0; bus_ack = 0; bus_rdata = '0;
      rand_delay = 0; spurious = 0; rd_force_en = 0; force_ack = 0; next_delay = 0;
      rd_force = '0; if_done_cnt = 0; d_done_cnt = 0; last_if_done_k = 0;
      do_reset(0);
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_bus_we", bus_we, 1'b0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_bus_be", bus_be, 4'd0);
      chk("rst_if_done", if_done, 1'b0);
      chk("rst_d_done", d_done, 1'b0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      chk("rst_stall_if", stall_if, 1'b0);
      chk("rst_stall_mem", stall_mem, 1'b0);
      chk("rst_bus_err", bus_err, 1'b0);

      // single fetch, ack two cycles after bus_req
      next_delay = 2; rd_force_en = 1; rd_force = 32'h00500093;
      if_addr = 32'h100; if_req = 1; t0 = k; base = if_done_cnt;
      for (int i = 0; i < 20 && if_req; i++) cycle();
      repeat (3) cycle();
      chk("fetch_latency", last_if_done_k - t0, 32'd4);
      chk("fetch_done_count", if_done_cnt - base, 32'd1);
      chk("fetch_rdata", if_rdata, 32'h00500093);

      // contention: data first, fetch right after its response
      rd_force_en = 0; next_delay = 1; rise_log.delete(); rise_k.delete();
      d_we = 0; d_addr = 32'h2000; d_be = 4'hF; d_req = 1;
      if_addr = 32'h104; if_req = 1;
      for (int i = 0; i < 30 && (if_req || d_req); i++) cycle();
      chk("contention_grants", rise_log.size(), 32'd2);
      if (rise_log.size() == 2) begin
         chk("contention_first", rise_log[0], 32'h2000);
         chk("contention_second", rise_log[1], 32'h104);
         chk("contention_gap", rise_k[1] - rise_k[0], 32'd4);
      end

      // starvation limit with data held continuously
      next_delay = 0; rise_log.delete(); rise_k.delete();
      exp_order = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h300, 32'h1010};
      if_addr = 32'h300; if_req = 1; dn = 0; d_addr = 32'h1000; d_req = 1;
      for (int i = 0; i < 60 && rise_log.size() < 6; i++) begin
         cycle();
         if (!d_req && rise_log.size() < 6) begin
            dn++;
            d_addr = 32'h1000 + 32'(dn * 4);
            d_req = 1;
         end
      end
      chk("starve_grants", rise_log.size(), 32'd6);
      for (int j = 0; j < 6 && j < rise_log.size(); j++) chk("starve_order", rise_log[j], exp_order[j]);
      drain(20);

      // store: bus carries the fields, d_rdata untouched
      next_delay = 1; rd_force_en = 1; rd_force = 32'hCAFEF00D; saved = e_d_rdata;
      rise_log.delete(); base = d_done_cnt;
      d_we = 1; d_be = 4'b0011; d_wdata = 32'hDEADBEEF; d_addr = 32'h4000; d_req = 1;
      for (int i = 0; i < 10 && d_req; i++) cycle();
      chk("store_grants", rise_log.size(), 32'd1);
      if (rise_log.size() == 1) chk("store_addr", rise_log[0], 32'h4000);
      chk("store_we", obs_we, 1'b1);
      chk("store_be", obs_be, 4'b0011);
      chk("store_wdata", obs_wdata, 32'hDEADBEEF);
      chk("store_done", d_done_cnt - base, 32'd1);
      chk("store_rdata_kept", d_rdata, saved);
      d_we = 0;

      // flush during BUS_I, then a clean fetch
      next_delay = 3; rd_force = 32'h00000013; rise_log.delete(); base = if_done_cnt;
      if_addr = 32'h180; if_req = 1;
      for (int i = 0; i < 5 && !bus_req; i++) cycle();
      if_kill = 1;
      cycle();
      for (int i = 0; i < 10 && act; i++) cycle();
      chk("flush_no_done", if_done_cnt - base, 32'd0);
      chk("flush_bus_released", bus_req, 1'b0);
      next_delay = 0; if_addr = 32'h200; if_req = 1;
      for (int i = 0; i < 10 && if_req; i++) cycle();
      chk("refetch_done", if_done_cnt - base, 32'd1);
      chk("refetch_rdata", if_rdata, 32'h00000013);
      if (rise_log.size() == 2) chk("refetch_addr", rise_log[1], 32'h200);
      else chk("flush_grants", rise_log.size(), 32'd2);

      // reset in the middle of a data transfer with a late ack
      rd_force_en = 0; next_delay = 100; base = d_done_cnt;
      d_we = 0; d_addr = 32'h5000; d_req = 1;
      repeat (3) cycle();
      chk("rstmid_busy", bus_req, 1'b1);
      do_reset(1);
      chk("rstmid_bus_req", bus_req, 1'b0);
      force_ack = 1;
      repeat (4) cycle();
      chk("rstmid_no_done", d_done_cnt - base, 32'd0);

`ifdef BUS_TIMEOUT_EN
      next_delay = 100000; base = d_done_cnt;
      d_addr = 32'h6000; d_req = 1;
      for (int i = 0; i < 300 && d_req; i++) cycle();
      chk("timeout_err", bus_err, 1'b1);
      chk("timeout_done", d_done_cnt - base, 32'd1);
      chk("timeout_rdata", d_rdata, 32'd0);
      do_reset(0);
      chk("timeout_err_clear", bus_err, 1'b0);
`endif

      // random traffic against the model
      rand_delay = 1; spurious = 1;
      for (int i = 0; i < 400; i++) begin
         if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = $urandom & 32'h0000FFFC;
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom & 32'h0000FFFC;
            d_wdata = $urandom; d_be = 4'($urandom_range(0, 15));
         end
         if (if_req && $urandom_range(0, 15) == 0) if_kill = 1;
         cycle();
      end
      spurious = 0;
      drain(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
